// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared definitions for the two-lane demultiplexer (demux_l2) and its lane
// FIFO (fifo_carril): default widths, routing-mode encodings, lane indices
// and the lane-selection helper.
// -----------------------------------------------------------------------------
package demux_pkg;

  localparam int ANCHO_DEF = 8;  // default data width
  localparam int PROF_DEF  = 4;  // default FIFO depth per lane (power of two)

  // Routing modes driven on the modo input.
  localparam logic MODO_SELECTOR = 1'b0;  // lane chosen by the selector input
  localparam logic MODO_ALTERNO  = 1'b1;  // lane chosen by the internal turno bit

  // Lane indices.
  localparam logic CARRIL0 = 1'b0;
  localparam logic CARRIL1 = 1'b1;

  // Target lane for the incoming word.
  function automatic logic lane_target(input logic modo,
                                       input logic selector,
                                       input logic turno);
    return (modo == MODO_ALTERNO) ? turno : selector;
  endfunction

endpackage : demux_pkg

// File: rtl/demux_l2_fifo_carril.sv
// -----------------------------------------------------------------------------
// fifo_carril
// Show-ahead FIFO for one output lane of demux_l2. The head word is always
// presented on dout; rd advances past it. Reading and writing in the same
// cycle is allowed even when full (occupancy then stays unchanged).
//
// Ports:
//   clk    in   clock, rising edge
//   reset  in   asynchronous active-high reset
//   wr     in   write din this cycle
//   din    in   [ANCHO-1:0] word to write
//   rd     in   consume the head word (ignored when empty)
//   dout   out  [ANCHO-1:0] head word, forced to 0 when empty
//   vacio  out  FIFO empty
//   lleno  out  FIFO holds PROF words
// -----------------------------------------------------------------------------
module fifo_carril
  import demux_pkg::*;
#(
  parameter int ANCHO = ANCHO_DEF,
  parameter int PROF  = PROF_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [ANCHO-1:0] din,
  input  logic             rd,
  output logic [ANCHO-1:0] dout,
  output logic             vacio,
  output logic             lleno
);

  localparam int PW = $clog2(PROF);  // pointer width
  localparam int CW = PW + 1;        // occupancy width, must reach PROF

  logic [ANCHO-1:0] r_mem [PROF];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_rd_eff;
  logic w_wr_eff;

  assign vacio = (r_count == '0);
  assign lleno = (r_count == CW'(PROF));

  // A pop on an empty lane is ignored; a write into a full lane is only
  // possible when the head is leaving in the same cycle.
  assign w_rd_eff = rd & ~vacio;
  assign w_wr_eff = wr & (~lleno | w_rd_eff);

  // NOTE: the storage array has no reset. Nothing can read a slot before it
  // has been written, and dout is gated while empty, so clearing it would
  // only add reset fan-out to every bit of memory.
  always_ff @(posedge clk) begin
    if (w_wr_eff) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of the others regardless of order.
  // Pointers wrap naturally because PROF is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_eff) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_eff) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_eff, w_rd_eff})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Show-ahead head word; forced to zero while empty so reset clears it too.
  assign dout = vacio ? '0 : r_mem[r_rd_ptr];

endmodule : fifo_carril

// File: rtl/demux_l2.sv
// -----------------------------------------------------------------------------
// demux_l2
// Splits one data stream into two lanes, each buffered by a show-ahead FIFO
// so the two consumers drain independently. The target lane comes from the
// selector input (modo=0) or from an internal alternating bit turno (modo=1)
// that undoes an upstream round-robin interleave. A word aimed at a full
// lane with no simultaneous pop is dropped and sets the sticky error flag.
//
// Ports:
//   clk                in   clock, rising edge
//   reset              in   asynchronous active-high reset
//   Entrada            in   [ANCHO-1:0] input word
//   validEntrada       in   Entrada carries a word this cycle
//   modo               in   0 = route by selector, 1 = alternate lanes
//   selector           in   target lane when modo=0
//   pop0 / pop1        in   consumer of lane 0 / 1 takes the head word
//   Salida0 / Salida1  out  [ANCHO-1:0] head word of lane 0 / 1
//   validSalida0 / 1   out  lane 0 / 1 not empty
//   lleno0 / lleno1    out  lane 0 / 1 full
//   error              out  sticky: a word was dropped on a full lane
// -----------------------------------------------------------------------------
module demux_l2
  import demux_pkg::*;
#(
  parameter int ANCHO = ANCHO_DEF,
  parameter int PROF  = PROF_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ANCHO-1:0] Entrada,
  input  logic             validEntrada,
  input  logic             modo,
  input  logic             selector,
  input  logic             pop0,
  input  logic             pop1,
  output logic [ANCHO-1:0] Salida0,
  output logic [ANCHO-1:0] Salida1,
  output logic             validSalida0,
  output logic             validSalida1,
  output logic             lleno0,
  output logic             lleno1,
  output logic             error
);

  logic r_turno;
  logic r_error;

  logic w_lane;
  logic w_vacio0;
  logic w_vacio1;
  logic w_acepta0;
  logic w_acepta1;
  logic w_wr0;
  logic w_wr1;
  logic w_drop;

  assign w_lane = lane_target(modo, selector, r_turno);

  // A full lane still accepts when its consumer pops in the same cycle
  // (a full lane is never empty, so that pop is always effective).
  assign w_acepta0 = ~lleno0 | pop0;
  assign w_acepta1 = ~lleno1 | pop1;

  assign w_wr0  = validEntrada & (w_lane == CARRIL0) & w_acepta0;
  assign w_wr1  = validEntrada & (w_lane == CARRIL1) & w_acepta1;
  assign w_drop = validEntrada & ~(w_wr0 | w_wr1);

  // turno advances on every valid word in alternating mode, written or
  // dropped, so lane alignment with the upstream interleave is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_turno <= 1'b0;
      r_error <= 1'b0;
    end else begin
      if (validEntrada && modo == MODO_ALTERNO) r_turno <= ~r_turno;
      if (w_drop) r_error <= 1'b1;
    end
  end

  assign error        = r_error;
  assign validSalida0 = ~w_vacio0;
  assign validSalida1 = ~w_vacio1;

  fifo_carril #(
    .ANCHO (ANCHO),
    .PROF  (PROF)
  ) u_carril0 (
    .clk   (clk),
    .reset (reset),
    .wr    (w_wr0),
    .din   (Entrada),
    .rd    (pop0),
    .dout  (Salida0),
    .vacio (w_vacio0),
    .lleno (lleno0)
  );

  fifo_carril #(
    .ANCHO (ANCHO),
    .PROF  (PROF)
  ) u_carril1 (
    .clk   (clk),
    .reset (reset),
    .wr    (w_wr1),
    .din   (Entrada),
    .rd    (pop1),
    .dout  (Salida1),
    .vacio (w_vacio1),
    .lleno (lleno1)
  );

endmodule : demux_l2

// File: tb/tb_demux_l2.sv
// -----------------------------------------------------------------------------
// tb_demux_l2
// Self-checking bench for demux_l2 (ANCHO=8, PROF=4). Inputs change on the
// falling edge, the DUT samples on the rising edge, outputs are compared on
// the following falling edge. The reference model keeps each lane as a queue
// of words plus the alternation bit and the sticky error flag.
// -----------------------------------------------------------------------------
module tb_demux_l2;

  localparam int ANCHO = 8;
  localparam int PROF  = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [ANCHO-1:0] Entrada = '0;
  logic             validEntrada = 1'b0;
  logic             modo = 1'b0;
  logic             selector = 1'b0;
  logic             pop0 = 1'b0;
  logic             pop1 = 1'b0;
  logic [ANCHO-1:0] Salida0, Salida1;
  logic             validSalida0, validSalida1, lleno0, lleno1, error;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  logic [ANCHO-1:0] q0[$];
  logic [ANCHO-1:0] q1[$];
  bit               m_turno = 1'b0;
  bit               m_error = 1'b0;

  demux_l2 #(.ANCHO(ANCHO), .PROF(PROF)) dut (
    .clk          (clk),
    .reset        (reset),
    .Entrada      (Entrada),
    .validEntrada (validEntrada),
    .modo         (modo),
    .selector     (selector),
    .pop0         (pop0),
    .pop1         (pop1),
    .Salida0      (Salida0),
    .Salida1      (Salida1),
    .validSalida0 (validSalida0),
    .validSalida1 (validSalida1),
    .lleno0       (lleno0),
    .lleno1       (lleno1),
    .error        (error)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before timeout");
    $fatal(1, "watchdog expired");
  end

  task automatic model_clear();
    q0.delete();
    q1.delete();
    m_turno = 1'b0;
    m_error = 1'b0;
  endtask

  // One clock cycle: apply inputs, let the DUT sample them, advance the model
  // with the same inputs, then return on the falling edge with inputs idle.
  task automatic cyc(input logic v, input logic [ANCHO-1:0] d, input logic m,
                     input logic s, input logic p0, input logic p1);
    bit e0, e1, t, acc;
    int sz;
    validEntrada = v; Entrada = d; modo = m; selector = s; pop0 = p0; pop1 = p1;
    @(posedge clk);
    e0  = p0 && (q0.size() > 0);
    e1  = p1 && (q1.size() > 0);
    t   = m ? m_turno : s;
    sz  = t ? q1.size() : q0.size();
    acc = (sz < PROF) || (t ? e1 : e0);
    if (e0) void'(q0.pop_front());
    if (e1) void'(q1.pop_front());
    if (v) begin
      if (acc) begin
        if (t) q1.push_back(d); else q0.push_back(d);
      end else begin
        m_error = 1'b1;
      end
      if (m) m_turno = ~m_turno;
    end
    @(negedge clk);
    validEntrada = 1'b0; pop0 = 1'b0; pop1 = 1'b0;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    validEntrada = 1'b0; pop0 = 1'b0; pop1 = 1'b0; modo = 1'b0; selector = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    #1;
    n_chk += 7;
    if (validSalida0 !== 1'b0) begin n_err++; $display("FAIL rst_valid0: got %b required 0", validSalida0); end
    if (validSalida1 !== 1'b0) begin n_err++; $display("FAIL rst_valid1: got %b required 0", validSalida1); end
    if (lleno0 !== 1'b0)       begin n_err++; $display("FAIL rst_lleno0: got %b required 0", lleno0); end
    if (lleno1 !== 1'b0)       begin n_err++; $display("FAIL rst_lleno1: got %b required 0", lleno1); end
    if (error !== 1'b0)        begin n_err++; $display("FAIL rst_error: got %b required 0", error); end
    if (Salida0 !== 8'h00)     begin n_err++; $display("FAIL rst_salida0: got %h required 00", Salida0); end
    if (Salida1 !== 8'h00)     begin n_err++; $display("FAIL rst_salida1: got %h required 00", Salida1); end
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_selector();
    reset_dut();
    cyc(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_chk += 2;
    if (validSalida0 !== 1'b1) begin n_err++; $display("FAIL sel_latency_valid0: got %b required 1", validSalida0); end
    if (Salida0 !== 8'hA1)     begin n_err++; $display("FAIL sel_latency_salida0: got %h required a1", Salida0); end
    cyc(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 1'b0);
    n_chk += 3;
    if (Salida0 !== 8'hA1)      begin n_err++; $display("FAIL sel_head0: got %h required a1", Salida0); end
    if (validSalida1 !== 1'b0)  begin n_err++; $display("FAIL sel_lane1_empty: got %b required 0", validSalida1); end
    if (lleno0 !== 1'b0)        begin n_err++; $display("FAIL sel_lleno0: got %b required 0", lleno0); end
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    n_chk += 2;
    if (Salida0 !== 8'hA2)     begin n_err++; $display("FAIL sel_pop_next: got %h required a2", Salida0); end
    if (validSalida0 !== 1'b1) begin n_err++; $display("FAIL sel_pop_valid: got %b required 1", validSalida0); end
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    n_chk += 1;
    if (validSalida0 !== 1'b0) begin n_err++; $display("FAIL sel_drained: got %b required 0", validSalida0); end
  endtask

  task automatic test_alternate();
    reset_dut();
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h10 + i), 1'b1, 1'b0, 1'b0, 1'b0);
    n_chk += 3;
    if (lleno0 !== 1'b1) begin n_err++; $display("FAIL alt_lleno0: got %b required 1", lleno0); end
    if (lleno1 !== 1'b1) begin n_err++; $display("FAIL alt_lleno1: got %b required 1", lleno1); end
    if (error !== 1'b0)  begin n_err++; $display("FAIL alt_error: got %b required 0", error); end
    for (int i = 0; i < 4; i++) begin
      n_chk += 2;
      if (Salida0 !== 8'(8'h10 + 2*i)) begin n_err++; $display("FAIL alt_drain0[%0d]: got %h required %h", i, Salida0, 8'(8'h10 + 2*i)); end
      if (Salida1 !== 8'(8'h11 + 2*i)) begin n_err++; $display("FAIL alt_drain1[%0d]: got %h required %h", i, Salida1, 8'(8'h11 + 2*i)); end
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    end
    n_chk += 2;
    if (validSalida0 !== 1'b0) begin n_err++; $display("FAIL alt_empty0: got %b required 0", validSalida0); end
    if (validSalida1 !== 1'b0) begin n_err++; $display("FAIL alt_empty1: got %b required 0", validSalida1); end
  endtask

  task automatic test_overflow();
    reset_dut();
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h51 + i), 1'b0, 1'b1, 1'b0, 1'b0);
    n_chk += 3;
    if (lleno1 !== 1'b1) begin n_err++; $display("FAIL ovf_lleno1: got %b required 1", lleno1); end
    if (error !== 1'b0)  begin n_err++; $display("FAIL ovf_error_before: got %b required 0", error); end
    if (lleno0 !== 1'b0) begin n_err++; $display("FAIL ovf_lleno0: got %b required 0", lleno0); end
    cyc(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
    n_chk += 1;
    if (error !== 1'b1) begin n_err++; $display("FAIL ovf_error_set: got %b required 1", error); end
    for (int i = 0; i < 4; i++) begin
      n_chk += 1;
      if (Salida1 !== 8'(8'h51 + i)) begin n_err++; $display("FAIL ovf_contents[%0d]: got %h required %h", i, Salida1, 8'(8'h51 + i)); end
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    end
    n_chk += 2;
    if (validSalida1 !== 1'b0) begin n_err++; $display("FAIL ovf_empty: got %b required 0", validSalida1); end
    if (error !== 1'b1)        begin n_err++; $display("FAIL ovf_error_sticky: got %b required 1", error); end
  endtask

  task automatic test_full_pop_write();
    reset_dut();
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h91 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h99, 1'b0, 1'b0, 1'b1, 1'b0);
    n_chk += 3;
    if (lleno0 !== 1'b1)   begin n_err++; $display("FAIL fpw_lleno0: got %b required 1", lleno0); end
    if (error !== 1'b0)    begin n_err++; $display("FAIL fpw_error: got %b required 0", error); end
    if (Salida0 !== 8'h92) begin n_err++; $display("FAIL fpw_head: got %h required 92", Salida0); end
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    n_chk += 1;
    if (lleno0 !== 1'b0) begin n_err++; $display("FAIL fpw_lleno_fall: got %b required 0", lleno0); end
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    n_chk += 2;
    if (Salida0 !== 8'h99)     begin n_err++; $display("FAIL fpw_tail_word: got %h required 99", Salida0); end
    if (validSalida0 !== 1'b1) begin n_err++; $display("FAIL fpw_tail_valid: got %b required 1", validSalida0); end
  endtask

  task automatic test_empty_pop();
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      n_chk += 2;
      if (validSalida1 !== 1'b0) begin n_err++; $display("FAIL epop_valid1[%0d]: got %b required 0", i, validSalida1); end
      if (error !== 1'b0)        begin n_err++; $display("FAIL epop_error[%0d]: got %b required 0", i, error); end
    end
    cyc(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 8'h3D, 1'b0, 1'b1, 1'b0, 1'b0);
    n_chk += 2;
    if (validSalida1 !== 1'b1) begin n_err++; $display("FAIL epop_wr_valid: got %b required 1", validSalida1); end
    if (Salida1 !== 8'h3C)     begin n_err++; $display("FAIL epop_wr_word: got %h required 3c", Salida1); end
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    n_chk += 1;
    if (Salida1 !== 8'h3D) begin n_err++; $display("FAIL epop_second: got %h required 3d", Salida1); end
  endtask

  task automatic test_mid_reset();
    reset_dut();
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h61 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'h71, 1'b1, 1'b0, 1'b0, 1'b0);  // turno 0 -> lane 0
    cyc(1'b1, 8'h72, 1'b1, 1'b0, 1'b0, 1'b0);  // turno 1 -> lane 1
    n_chk += 3;
    if (error !== 1'b1)        begin n_err++; $display("FAIL mrst_pre_error: got %b required 1", error); end
    if (validSalida1 !== 1'b1) begin n_err++; $display("FAIL mrst_pre_valid1: got %b required 1", validSalida1); end
    if (Salida0 !== 8'h63)     begin n_err++; $display("FAIL mrst_pre_head0: got %h required 63", Salida0); end
    // Assert reset between edges: outputs must clear without a clock edge.
    #2 reset = 1'b1;
    #1;
    n_chk += 7;
    if (validSalida0 !== 1'b0) begin n_err++; $display("FAIL mrst_valid0: got %b required 0", validSalida0); end
    if (validSalida1 !== 1'b0) begin n_err++; $display("FAIL mrst_valid1: got %b required 0", validSalida1); end
    if (lleno0 !== 1'b0)       begin n_err++; $display("FAIL mrst_lleno0: got %b required 0", lleno0); end
    if (lleno1 !== 1'b0)       begin n_err++; $display("FAIL mrst_lleno1: got %b required 0", lleno1); end
    if (error !== 1'b0)        begin n_err++; $display("FAIL mrst_error: got %b required 0", error); end
    if (Salida0 !== 8'h00)     begin n_err++; $display("FAIL mrst_salida0: got %h required 00", Salida0); end
    if (Salida1 !== 8'h00)     begin n_err++; $display("FAIL mrst_salida1: got %h required 00", Salida1); end
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    cyc(1'b1, 8'hE0, 1'b1, 1'b1, 1'b0, 1'b0);
    n_chk += 3;
    if (validSalida0 !== 1'b1) begin n_err++; $display("FAIL mrst_turno_lane0: got %b required 1", validSalida0); end
    if (Salida0 !== 8'hE0)     begin n_err++; $display("FAIL mrst_turno_word: got %h required e0", Salida0); end
    if (validSalida1 !== 1'b0) begin n_err++; $display("FAIL mrst_turno_lane1: got %b required 0", validSalida1); end
  endtask

  task automatic test_random();
    logic m;
    reset_dut();
    m = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) m = ~m;
      cyc($urandom_range(0, 9) < 7, 8'($urandom), m, 1'($urandom),
          $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4);
      n_chk += 5;
      if (validSalida0 !== (q0.size() != 0))   begin n_err++; $display("FAIL rnd_valid0[%0d]: got %b required %b", i, validSalida0, q0.size() != 0); end
      if (validSalida1 !== (q1.size() != 0))   begin n_err++; $display("FAIL rnd_valid1[%0d]: got %b required %b", i, validSalida1, q1.size() != 0); end
      if (lleno0 !== (q0.size() == PROF))      begin n_err++; $display("FAIL rnd_lleno0[%0d]: got %b required %b", i, lleno0, q0.size() == PROF); end
      if (lleno1 !== (q1.size() == PROF))      begin n_err++; $display("FAIL rnd_lleno1[%0d]: got %b required %b", i, lleno1, q1.size() == PROF); end
      if (error !== m_error)                   begin n_err++; $display("FAIL rnd_error[%0d]: got %b required %b", i, error, m_error); end
      if (q0.size() != 0) begin
        n_chk++;
        if (Salida0 !== q0[0]) begin n_err++; $display("FAIL rnd_salida0[%0d]: got %h required %h", i, Salida0, q0[0]); end
      end
      if (q1.size() != 0) begin
        n_chk++;
        if (Salida1 !== q1[0]) begin n_err++; $display("FAIL rnd_salida1[%0d]: got %h required %h", i, Salida1, q1[0]); end
      end
      // Occasionally clear the sticky flag so later drops are observed again.
      if (m_error && $urandom_range(0, 29) == 0) reset_dut();
    end
  endtask

  initial begin
    test_reset();
    test_selector();
    test_alternate();
    test_overflow();
    test_full_pop_write();
    test_empty_pop();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_demux_l2
